// File: rtl/pooled_fmap_stream_reader.sv
// Streams a 32ch x 16x16 pooled feature map of 4-bit activations out of MRAM.
// Each 32-bit word holds eight nibbles, most significant nibble first.
module pooled_fmap_stream_reader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pool_start,
  input  logic        pool_done,
  output logic        mram_en_b,
  output logic [9:0]  mram_addr_b,
  input  logic [31:0] mram_dout,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [3:0]  m_data,
  output logic        m_last,
  output logic [4:0]  m_ch,
  output logic [3:0]  m_row,
  output logic [3:0]  m_col
);

  typedef enum logic [2:0] {
    IDLE, POOL_START, WAIT_POOL, FETCH, LATCH, STREAM, DONE
  } state_t;

  state_t      state, state_next;
  logic [9:0]  word_idx;
  logic [2:0]  nib_idx;
  logic [31:0] word_reg;
  logic [12:0] flat;
  logic        hs, word_end, map_end;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    hs         = (state == STREAM) && m_ready;
    word_end   = (nib_idx == 3'd7);
    map_end    = word_end && (word_idx == 10'd1023);
    state_next = state;
    case (state)
      IDLE:       if (start) state_next = POOL_START;
      POOL_START: state_next = WAIT_POOL;
      WAIT_POOL:  if (pool_done) state_next = FETCH;
      FETCH:      state_next = LATCH;
      LATCH:      state_next = STREAM;
      STREAM:     if (hs && word_end) state_next = map_end ? DONE : FETCH;
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      word_idx <= '0;
      nib_idx  <= '0;
      word_reg <= '0;
    end else begin
      state <= state_next;
      case (state)
        POOL_START: begin
          word_idx <= '0;
          nib_idx  <= '0;
        end
        LATCH: word_reg <= mram_dout;
        STREAM: begin
          if (hs) begin
            if (!word_end) begin
              nib_idx <= nib_idx + 3'd1;
            end else if (!map_end) begin
              // The final element keeps its indices so the tag stays (31,15,15).
              nib_idx  <= '0;
              word_idx <= word_idx + 10'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign flat        = {word_idx, nib_idx};
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign pool_start  = (state == POOL_START);
  assign mram_en_b   = (state == FETCH);
  assign mram_addr_b = (state == FETCH) ? word_idx : 10'd0;
  assign m_valid     = (state == STREAM);
  assign m_last      = (state == STREAM) && map_end;
  assign m_data      = word_reg[5'd31 - {nib_idx, 2'b00} -: 4];
  assign m_ch        = flat[12:8];
  assign m_row       = flat[7:4];
  assign m_col       = flat[3:0];

endmodule
